// File: rtl/data_mem.sv
// Byte-writable data RAM plus a three-word constant table for the load/store path.
// Reads and write echoes are combinational; only RAM updates are clocked.
module data_mem #(
  parameter int unsigned      DEPTH     = 256,
  parameter logic [31:0]      DMEM_BASE = 32'h80000000,
  parameter logic [31:0]      ROM_BASE  = 32'h00100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  en,
  input  logic [3:0]  w_en,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;
  localparam logic [31:0] ROM_BYTES = 32'd12;

  localparam logic [1:0] EN_READ  = 2'b01;
  localparam logic [1:0] EN_WRITE = 2'b10;

  logic [31:0]      mem_r [DEPTH];
  logic [31:0]      ram_off_s;
  logic [31:0]      rom_off_s;
  logic             ram_hit_s;
  logic             rom_hit_s;
  logic [IDX_W-1:0] idx_s;
  logic             wr_s;
  logic [31:0]      dout_s;

  // Expand the four lane enables into a 32-bit byte mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] lanes);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

  // Fixed constant table contents.
  function automatic logic [31:0] rom_word(input logic [1:0] w);
    logic [31:0] v;
    case (w)
      2'd0:    v = 32'h11987251;
      2'd1:    v = 32'h18790475;
      2'd2:    v = 32'h10257233;
      default: v = 32'h00000000;
    endcase
    return v;
  endfunction

  // Offsets wrap below the base, so one unsigned compare covers both range ends.
  assign ram_off_s = addr - DMEM_BASE;
  assign rom_off_s = addr - ROM_BASE;
  assign ram_hit_s = (ram_off_s < RAM_BYTES);
  assign rom_hit_s = (rom_off_s < ROM_BYTES);
  assign idx_s     = ram_off_s[IDX_W+1:2];
  assign wr_s      = (en == EN_WRITE) && ram_hit_s;

  // RAM storage: asynchronous clear, byte-lane writes to mapped words only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (w_en[b]) begin
          mem_r[idx_s][8*b +: 8] <= din[8*b +: 8];
        end
      end
    end
  end

  // Output mux: reset marker, read data, or masked write echo.
  always_comb begin
    dout_s = 32'h0;
    if (rst) begin
      dout_s = 32'h00000001;
    end else begin
      case (en)
        EN_READ: begin
          if (ram_hit_s) begin
            dout_s = mem_r[idx_s];
          end else if (rom_hit_s) begin
            dout_s = rom_word(rom_off_s[3:2]);
          end else begin
            dout_s = 32'h0;
          end
        end
        EN_WRITE: dout_s = din & byte_mask(w_en);
        default:  dout_s = 32'h0;
      endcase
    end
  end

  assign dout = dout_s;

endmodule

// File: tb/tb_data_mem.sv
// Directed scoreboard bench for data_mem: expected words are queued when
// stimulus is driven and checked at the following falling edge.
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic [3:0]  w_en;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          n_checks;
  int          n_fails;

  data_mem dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .w_en (w_en),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_one();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL scoreboard_empty: observed %h, required a queued value", dout);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (dout === e) else begin
        n_fails++;
        $error("FAIL %s: observed %h required %h", t, dout, e);
      end
    end
  endtask

  // Drive one operation just after a rising edge, check it at the falling edge.
  task automatic step(input logic [1:0] e_en, input logic [3:0] e_wen,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] expv, input string t);
    @(posedge clk);
    #1;
    en   = e_en;
    w_en = e_wen;
    addr = a;
    din  = d;
    push_exp(expv, t);
    @(negedge clk);
    check_one();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset held with a write presented: dout forced to 1, write discarded.
    rst  = 1'b1;
    en   = 2'b10;
    w_en = 4'b0001;
    addr = 32'h80000000;
    din  = 32'h20221118;
    push_exp(32'h00000001, "reset_dout");
    @(posedge clk);
    @(negedge clk);
    check_one();
    en  = 2'b00;
    rst = 1'b0;

    step(2'b01, 4'b0000, 32'h80000000, 32'h0, 32'h00000000, "reset_write_dropped");
    step(2'b00, 4'b1111, 32'h80000000, 32'h20221118, 32'h00000000, "idle_00");

    // Byte-lane write echoes.
    step(2'b10, 4'b0001, 32'h80000000, 32'h20221118, 32'h00000018, "echo_0001");
    step(2'b10, 4'b0010, 32'h80000000, 32'h20221118, 32'h00001100, "echo_0010");
    step(2'b10, 4'b0100, 32'h80000000, 32'h20221118, 32'h00220000, "echo_0100");
    step(2'b10, 4'b1000, 32'h80000000, 32'h20221118, 32'h20000000, "echo_1000");
    step(2'b10, 4'b0011, 32'h80000000, 32'h20221118, 32'h00001118, "echo_0011");
    step(2'b10, 4'b0000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "echo_0000");
    step(2'b01, 4'b1111, 32'h80000000, 32'h0, 32'h20221118, "read_lanes_word0");

    // Constant table.
    step(2'b01, 4'b0000, 32'h00100000, 32'h0, 32'h11987251, "rom0");
    step(2'b01, 4'b0000, 32'h00100004, 32'h0, 32'h18790475, "rom1");
    step(2'b01, 4'b0000, 32'h00100008, 32'h0, 32'h10257233, "rom2");
    step(2'b01, 4'b0000, 32'h0010000A, 32'h0, 32'h10257233, "rom2_lowbits");
    step(2'b01, 4'b0000, 32'h0010000C, 32'h0, 32'h00000000, "rom_past_end");

    // Partial overwrite keeps untouched lanes.
    step(2'b10, 4'b1111, 32'h80000010, 32'hAABBCCDD, 32'hAABBCCDD, "full_write");
    step(2'b10, 4'b0010, 32'h80000010, 32'h00001100, 32'h00001100, "partial_write");
    step(2'b01, 4'b0000, 32'h80000010, 32'h0, 32'hAABB11DD, "merge_read");

    // ROM not writable, unmapped reads zero, en=11 idle.
    step(2'b10, 4'b1111, 32'h00100000, 32'h20221118, 32'h20221118, "rom_write_echo");
    step(2'b01, 4'b0000, 32'h00100000, 32'h0, 32'h11987251, "rom_unchanged");
    step(2'b01, 4'b0000, 32'h40000000, 32'h0, 32'h00000000, "unmapped_read");
    step(2'b11, 4'b1111, 32'h80000010, 32'h12345678, 32'h00000000, "idle_11");
    step(2'b01, 4'b0000, 32'h80000010, 32'h0, 32'hAABB11DD, "idle_11_no_write");

    // RAM range boundaries; past-end write must not alias onto word 0.
    step(2'b10, 4'b1111, 32'h800003FC, 32'h12345678, 32'h12345678, "last_word_write");
    step(2'b10, 4'b1111, 32'h80000400, 32'hDEADBEEF, 32'hDEADBEEF, "past_end_write");
    step(2'b01, 4'b0000, 32'h800003FC, 32'h0, 32'h12345678, "last_word_read");
    step(2'b01, 4'b0000, 32'h80000400, 32'h0, 32'h00000000, "past_end_read");
    step(2'b01, 4'b0000, 32'h80000000, 32'h0, 32'h20221118, "word0_not_aliased");
    step(2'b10, 4'b1111, 32'h7FFFFFFC, 32'hDEADBEEF, 32'hDEADBEEF, "below_base_write");
    step(2'b01, 4'b0000, 32'h7FFFFFFC, 32'h0, 32'h00000000, "below_base_read");
    step(2'b01, 4'b0000, 32'h800003FC, 32'h0, 32'h12345678, "last_word_kept");

    // Mid-cycle reset: output forced at once, RAM cleared, write discarded.
    step(2'b10, 4'b1111, 32'h80000020, 32'hCAFEF00D, 32'hCAFEF00D, "fill_write");
    step(2'b01, 4'b0000, 32'h80000020, 32'h0, 32'hCAFEF00D, "fill_read");
    @(posedge clk);
    #2;
    en   = 2'b10;
    w_en = 4'b1111;
    addr = 32'h80000020;
    din  = 32'hFFFFFFFF;
    rst  = 1'b1;
    #1;
    push_exp(32'h00000001, "mid_reset_dout");
    check_one();
    en  = 2'b00;
    rst = 1'b0;

    step(2'b01, 4'b0000, 32'h80000020, 32'h0, 32'h00000000, "cleared_fill");
    step(2'b01, 4'b0000, 32'h80000010, 32'h0, 32'h00000000, "cleared_merge");
    step(2'b01, 4'b0000, 32'h800003FC, 32'h0, 32'h00000000, "cleared_last");
    step(2'b01, 4'b0000, 32'h80000000, 32'h0, 32'h00000000, "cleared_word0");
    step(2'b01, 4'b0000, 32'h00100004, 32'h0, 32'h18790475, "rom_after_reset");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL scoreboard_leftover: observed %0d entries, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
